// File: rtl/dff_bank_pkg.sv
// Shared types and helpers for the round-robin register-bank arbiter.
// State encoding, default sizes and a one-hot to index converter.
package dff_bank_pkg;

   localparam int NREQ_DEF  = 4;
   localparam int WIDTH_DEF = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Index of the set bit in a one-hot vector of up to 8 bits
   function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
      logic [2:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) r = r | 3'(i);
      end
      return r;
   endfunction

endpackage

// File: rtl/dff_bank_arbiter_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after
// ptr, wrapping modulo NREQ.
module rr_pick #(
   parameter int NREQ = 4,
   parameter int IDW  = 2
) (
   input  logic [NREQ-1:0] eligible,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] win_oh,
   output logic [IDW-1:0]  win_idx
);

   // Walk NREQ positions from ptr, keep the first eligible one
   always_comb begin
      int         j;
      logic       found;
      logic [IDW-1:0] jj;
      win_oh  = '0;
      win_idx = '0;
      found   = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         jj = IDW'(j);
         if (!found && eligible[jj]) begin
            found       = 1'b1;
            win_oh[jj]  = 1'b1;
            win_idx     = jj;
         end
      end
   end

endmodule

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter writing one requester's word per grant into a shared
// register. Optional burst lock is compiled in with macro LOCK_EN.
module dff_bank_arbiter
   import dff_bank_pkg::*;
#(
   parameter  int NREQ  = NREQ_DEF,
   parameter  int WIDTH = WIDTH_DEF,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] req_data,
   input  logic [NREQ-1:0]       req_lock,
   output logic [NREQ-1:0]       gnt,
   output logic [WIDTH-1:0]      q,
   output logic                  q_valid,
   output logic [IDW-1:0]        q_owner
);

   state_t          state;
   logic [IDW-1:0]  ptr;
   logic [NREQ-1:0] eligible;
   logic [NREQ-1:0] win_oh;
   logic [IDW-1:0]  win_idx;
   logic [NREQ-1:0] nxt_oh;
   logic [IDW-1:0]  nxt_ptr;
   logic            hold;
   logic            adv;
   logic [7:0]      gnt8;
   logic [IDW-1:0]  cur_idx;
   logic [WIDTH-1:0] sel_data;

   assign eligible = req & ~gnt;

   rr_pick #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_pick (
      .eligible (eligible),
      .ptr      (ptr),
      .win_oh   (win_oh),
      .win_idx  (win_idx)
   );

`ifdef LOCK_EN
   // A locked holder keeps the grant and freezes the pointer
   assign hold = |(gnt & req & req_lock);
   assign adv  = !hold && (|win_oh) && !req_lock[win_idx];
`else
   logic unused_lock;
   assign unused_lock = ^req_lock;
   assign hold = 1'b0;
   assign adv  = |win_oh;
`endif

   assign nxt_oh  = hold ? gnt : win_oh;
   assign nxt_ptr = (win_idx == IDW'(NREQ - 1)) ? '0 : win_idx + IDW'(1);

   // Widen grant for the shared index helper
   always_comb begin
      gnt8 = '0;
      gnt8[NREQ-1:0] = gnt;
   end

   assign cur_idx = IDW'(onehot_to_idx(gnt8));

   // AND-OR select of the granted requester's data word
   always_comb begin
      sel_data = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (gnt[i]) sel_data = sel_data | req_data[i*WIDTH +: WIDTH];
      end
   end

   // Grant FSM with registered one-hot grant and priority pointer
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         gnt   <= '0;
         ptr   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (|nxt_oh) begin
                  state <= GRANT;
                  gnt   <= nxt_oh;
                  if (adv) ptr <= nxt_ptr;
               end else begin
                  gnt <= '0;
               end
            end
            GRANT: begin
               if (|nxt_oh) begin
                  gnt <= nxt_oh;
                  if (adv) ptr <= nxt_ptr;
               end else begin
                  state <= IDLE;
                  gnt   <= '0;
               end
            end
         endcase
      end
   end

   // Load the shared register at the end of each grant cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q       <= '0;
         q_valid <= 1'b0;
         q_owner <= '0;
      end else begin
         q_valid <= |gnt;
         if (|gnt) begin
            q       <= sel_data;
            q_owner <= cur_idx;
         end
      end
   end

endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Directed and randomized checks of dff_bank_arbiter against a
// queue-free round-robin reference model.
module tb_dff_bank_arbiter;

   localparam int N = 4;
   localparam int W = 8;

   logic         clk;
   logic         reset;
   logic [N-1:0] req;
   logic [N-1:0] req_lock;
   logic [N*W-1:0] req_data;
   logic [W-1:0] d [N];
   logic [N-1:0] gnt;
   logic [W-1:0] q;
   logic         q_valid;
   logic [1:0]   q_owner;

   int n_cmp;
   int n_err;

   int         m_gnt;
   int         m_ptr;
   logic [W-1:0] m_q;
   logic       m_qv;
   int         m_own;

   dff_bank_arbiter #(
      .NREQ  (N),
      .WIDTH (W)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .req      (req),
      .req_data (req_data),
      .req_lock (req_lock),
      .gnt      (gnt),
      .q        (q),
      .q_valid  (q_valid),
      .q_owner  (q_owner)
   );

   always #5 clk = ~clk;

   always_comb begin
      req_data = '0;
      for (int i = 0; i < N; i++) req_data[i*W +: W] = d[i];
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_gnt = -1;
      m_ptr = 0;
      m_q   = '0;
      m_qv  = 1'b0;
      m_own = 0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      model_reset();
      #1;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_q", 32'(q), 0);
      chk("rst_qv", 32'(q_valid), 0);
      chk("rst_own", 32'(q_owner), 0);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Advance one clock: predict from the rules, then compare outputs
   task automatic step();
      int win;
      bit lk;
      int i;
      logic [31:0] eg;
      if (m_gnt >= 0) begin
         m_q   = d[m_gnt];
         m_qv  = 1'b1;
         m_own = m_gnt;
      end else begin
         m_qv = 1'b0;
      end
      win = -1;
      lk  = 1'b0;
`ifdef LOCK_EN
      if (m_gnt >= 0 && req[m_gnt] && req_lock[m_gnt]) begin
         win = m_gnt;
         lk  = 1'b1;
      end
`endif
      if (!lk) begin
         for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (win < 0 && req[i] && i != m_gnt) win = i;
         end
         if (win >= 0) begin
`ifdef LOCK_EN
            if (!req_lock[win]) m_ptr = (win + 1) % N;
`else
            m_ptr = (win + 1) % N;
`endif
         end
      end
      m_gnt = win;
      @(posedge clk);
      #1;
      eg = (m_gnt >= 0) ? (32'd1 << m_gnt) : 32'd0;
      chk("gnt", 32'(gnt), eg);
      chk("q", 32'(q), 32'(m_q));
      chk("q_valid", 32'(q_valid), 32'(m_qv));
      chk("q_owner", 32'(q_owner), 32'(m_own));
   endtask

   initial begin
      n_cmp    = 0;
      n_err    = 0;
      clk      = 1'b0;
      reset    = 1'b1;
      req      = '0;
      req_lock = '0;
      for (int i = 0; i < N; i++) d[i] = '0;
      #1;
      do_reset();

      // single request from requester 0
      d[0] = 8'hA5;
      req  = 4'b0001;
      step();
      chk("t1_gnt", 32'(gnt), 32'h1);
      req = 4'b0000;
      step();
      chk("t1_gnt0", 32'(gnt), 32'h0);
      chk("t1_q", 32'(q), 32'hA5);
      chk("t1_qv", 32'(q_valid), 32'h1);
      chk("t1_own", 32'(q_owner), 32'h0);

      // all four held: strict rotation 0,1,2,3
      do_reset();
      for (int i = 0; i < N; i++) d[i] = 8'(8'h10 + i);
      req = 4'b1111;
      step();
      chk("t2_g0", 32'(gnt), 32'h1);
      for (int i = 1; i < N; i++) begin
         step();
         chk("t2_g", 32'(gnt), 32'd1 << i);
         chk("t2_q", 32'(q), 32'(8'h10 + i - 1));
      end
      step();
      chk("t2_q3", 32'(q), 32'h13);
      req = '0;
      step();
      step();

      // pointer wrap after grant to 2
      do_reset();
      req = 4'b0100;
      step();
      chk("t3_g2", 32'(gnt), 32'h4);
      req = 4'b0101;
      step();
      chk("t3_g0", 32'(gnt), 32'h1);
      step();
      chk("t3_g2b", 32'(gnt), 32'h4);
      req = '0;
      step();
      step();

      // idle stretch: q holds, no valid pulses
      for (int k = 0; k < 5; k++) step();
      chk("t5_q", 32'(q), 32'(d[2]));
      req = 4'b1111;
      step();
      req = '0;
      step();
      step();

      // reset asserted mid-grant
      d[1] = 8'h5C;
      req  = 4'b0010;
      step();
      chk("t4_g1", 32'(gnt), 32'h2);
      #3;
      do_reset();
      req = 4'b1111;
      step();
      chk("t4_after", 32'(gnt), 32'h1);
      req = '0;
      step();
      step();

      // burst lock on requester 1 with requester 3 waiting
      do_reset();
      d[1] = 8'h31;
      d[3] = 8'h33;
      req      = 4'b1010;
      req_lock = 4'b0010;
      step();
      chk("t6_w1", 32'(gnt), 32'h2);
      step();
`ifdef LOCK_EN
      chk("t6_w2", 32'(gnt), 32'h2);
`else
      chk("t6_w2", 32'(gnt), 32'h8);
`endif
      step();
      chk("t6_w3", 32'(gnt), 32'h2);
      req      = 4'b1000;
      req_lock = 4'b0000;
      step();
      chk("t6_w4", 32'(gnt), 32'h8);
      req = '0;
      step();
      step();

      // randomized requesters obeying the drop-on-grant protocol
      for (int c = 0; c < 300; c++) begin
         for (int i = 0; i < N; i++) begin
            if (m_gnt == i) begin
               req[i] = 1'b0;
            end else if (!req[i] && $urandom_range(0, 2) == 0) begin
               req[i] = 1'b1;
               d[i]   = 8'($urandom);
            end
         end
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter sharing one WIDTH-bit register (a bank of D flip-flops) between NREQ requesters.
- Each grant writes the winning requester's data word into the shared register and reports the owner.
- Sits between request sources and the shared register bank; it owns the register's write enable and data select.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 8, shared register width in bits
IDW, $clog2(NREQ), owner index width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
req  input  NREQ  request per requester; must hold with data stable until its gnt bit is seen
req_data  input  NREQ*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
req_lock  input  NREQ  burst lock per requester; ignored unless LOCK_EN
gnt  output  NREQ  registered one-hot grant, high one cycle per granted word
q  output  WIDTH  shared register contents
q_valid  output  1  one-cycle pulse: q updated this cycle
q_owner  output  IDW  index of requester that last wrote q

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-high.
- Reset, asynchronous and immediate, including mid-grant: gnt=0, q=0, q_valid=0, q_owner=0, priority pointer=0 (requester 0 highest). No pending grant survives reset.
- Arbitration each cycle over eligible = req & ~gnt. The currently granted bit is masked, so one request is consumed per grant. The requester drops req in the cycle its gnt is high.
- Round-robin: search starts at ptr and wraps modulo NREQ; first eligible wins. On grant to i, ptr becomes (i+1) mod NREQ.
- Latency: req rises before edge k, gnt[i] high in cycle k..k+1, q loaded at the edge ending the gnt cycle. q_valid and q_owner=i then valid for one cycle.
- Data captured is req_data slice i sampled during the gnt cycle.
- Back-to-back: a different requester may be granted in the cycle right after a grant. Peak throughput is one word per cycle. A lone requester re-requesting gets every other cycle.
- No eligible request: gnt=0, q holds, q_valid=0, ptr holds.
- FSM, 2 states:
  - IDLE: gnt=0; go to GRANT if eligible≠0.
  - GRANT: gnt one-hot; stay if eligible≠0, else go to IDLE.
- q_owner holds its value until the next write.

Optional Feature:
- Macro LOCK_EN.
- Defined: if req_lock[i] and req[i] are high while gnt[i] is high, i is not masked and wins the next cycle regardless of ptr. ptr does not advance during the lock. ptr advances past i on the first grant where req_lock[i] is low. This gives multi-word bursts with a q_valid pulse per word.
- Undefined: req_lock is unused, and behaviour is exactly as above.

Decomposition:
- Package dff_bank_pkg: state enum (IDLE, GRANT), default NREQ/WIDTH constants, and a one-hot-to-index function.
- Sub-module rr_pick: combinational round-robin picker. Inputs: eligible vector and ptr. Outputs: one-hot winner and index.
- Top holds the FSM, ptr, gnt/q/q_valid/q_owner registers.

Test Plan:
- Reset then req=4'b0001, data0=8'hA5 -> gnt=0001 one cycle; next cycle q=8'hA5, q_valid=1, q_owner=0.
- req=4'b1111 held continuously, data i=8'h10+i -> grants in order 0,1,2,3 on consecutive cycles; q sequence 10,11,12,13.
- After grant to 2, req=4'b0101 -> next grant to 0, because ptr=3 wraps to 0; then 2.
- Assert reset while gnt=0010 mid-cycle -> gnt, q, q_valid, q_owner drop to 0 immediately; next arbitration starts from requester 0.
- Idle 5 cycles with req=0 -> q holds last value, q_valid stays 0, ptr unchanged.
- LOCK_EN: req1+lock1 for 3 words, req3 pending -> gnt1 three consecutive cycles, then gnt3; without LOCK_EN -> gnt1, gnt3, gnt1 alternating.
